// File: rtl/des_pkg.sv
// DES key-schedule constants: PC1/PC2 selection tables (1-based DES numbering),
// per-round rotation amounts and the half-key rotation helpers.
package des_pkg;

    localparam int KEY_W = 64;
    localparam int CD_W  = 28;
    localparam int SK_W  = 48;

    localparam logic [5:0] PC1_TBL [0:55] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,
        6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6,
        6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
        6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_TBL [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    localparam logic [1:0] SHIFTS [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Bit 0 of every vector is DES bit 1, so table entry n selects index n-1.
    function automatic logic [0:55] pc1(input logic [0:63] key);
        logic [0:55] cd;
        logic [5:0]  idx;
        cd  = '0;
        idx = 6'd0;
        for (int i = 0; i < 56; i++) begin
            idx   = PC1_TBL[i] - 6'd1;
            cd[i] = key[idx];
        end
        return cd;
    endfunction

    function automatic logic [0:27] rotl28(input logic [0:27] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
    endfunction

    function automatic logic [0:27] rotr28(input logic [0:27] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: pure wiring from the 56-bit C||D halves to a 48-bit
// round subkey. Kept separate so an unrolled schedule can instantiate sixteen.
module des_pc2
    import des_pkg::*;
(
    input  logic [0:55] cd_i,
    output logic [0:47] sk_o
);

    logic [5:0] idx_s;

    // Select each subkey bit from its PC2 source position.
    always_comb begin
        sk_o  = '0;
        idx_s = 6'd0;
        for (int i = 0; i < SK_W; i++) begin
            idx_s   = PC2_TBL[i] - 6'd1;
            sk_o[i] = cd_i[idx_s];
        end
    end

endmodule

// File: rtl/des_subkey_gen.sv
// Sequential DES key schedule: loads one key, then streams K1..K16 (or
// K16..K1 for decryption) over a valid/ready handshake, one subkey per beat.
module des_subkey_gen
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:63] key_in,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        decrypt,
    output logic [0:47] sk_out,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [3:0]  sk_round,
    output logic        sk_last
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    logic [0:0]  state_q, state_d;
    logic [0:27] c_q, c_d;
    logic [0:27] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;

    logic [0:55] key_pc1_s;
    logic [3:0]  shift_idx_s;
    logic [1:0]  shift_s;
    logic [0:47] sk_pc2_s;

    assign key_pc1_s = pc1(key_in);

    // Encrypt steps forward through the table; decrypt walks it backwards
    // starting from the fully rotated (K16) position.
    always_comb begin
        shift_idx_s = 4'd0;
        if (mode_q) begin
            shift_idx_s = 4'd15 - round_q;
        end else begin
            shift_idx_s = round_q + 4'd1;
        end
        shift_s = SHIFTS[shift_idx_s];
    end

    // Next-state logic for the load/emit sequencer.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    // Encrypt pre-applies the first rotation so K1 is ready next cycle.
                    if (decrypt) begin
                        c_d = key_pc1_s[0:27];
                        d_d = key_pc1_s[28:55];
                    end else begin
                        c_d = rotl28(key_pc1_s[0:27], 2'd1);
                        d_d = rotl28(key_pc1_s[28:55], 2'd1);
                    end
                    mode_d  = decrypt;
                    round_d = 4'd0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sk_ready) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_IDLE;
                    end else begin
                        round_d = round_q + 4'd1;
                        if (mode_q) begin
                            c_d = rotr28(c_q, shift_s);
                            d_d = rotr28(d_q, shift_s);
                        end else begin
                            c_d = rotl28(c_q, shift_s);
                            d_d = rotl28(d_q, shift_s);
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= 4'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    des_pc2 u_pc2 (
        .cd_i ({c_q, d_q}),
        .sk_o (sk_pc2_s)
    );

    assign sk_out    = sk_pc2_s;
    assign key_ready = (state_q == ST_IDLE);
    assign sk_valid  = (state_q == ST_RUN);
    assign sk_round  = round_q;
    assign sk_last   = (state_q == ST_RUN) && (round_q == LAST_ROUND);

endmodule

// File: tb/tb_des_subkey_gen.sv
// Directed bench for des_subkey_gen using the classic 0x133457799BBCDFF1 key
// schedule plus all-zero / all-one keys, back-pressure and mid-stream reset.
module tb_des_subkey_gen;

    logic        clk;
    logic        rst_n;
    logic [63:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic        decrypt;
    logic [47:0] sk_out;
    logic        sk_valid;
    logic        sk_ready;
    logic [3:0]  sk_round;
    logic        sk_last;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] TEST_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR_KEY  = 64'h123556789ABDDEF0;

    logic [47:0] k_exp [0:15] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic [47:0] cap_sk   [0:15];
    logic [3:0]  cap_rnd  [0:15];
    logic        cap_last [0:15];
    int          stall_glitch;
    int          stall_cycles;
    logic        timed_out;

    des_subkey_gen #(.NUM_ROUNDS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .decrypt   (decrypt),
        .sk_out    (sk_out),
        .sk_valid  (sk_valid),
        .sk_ready  (sk_ready),
        .sk_round  (sk_round),
        .sk_last   (sk_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Present a key for one cycle with sk_ready held low.
    task automatic load_key(input logic [63:0] k, input logic dec);
        @(negedge clk);
        sk_ready  = 1'b0;
        key_in    = k;
        decrypt   = dec;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Consume 16 subkeys, optionally stalling randomly and injecting a stray key.
    task automatic consume_stream(input int stall, input int inject);
        int n;
        int cyc;
        logic prev_stall;
        logic [52:0] prev_out;
        n = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
        stall_glitch = 0; stall_cycles = 0; timed_out = 1'b0;
        while (n < 16 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (prev_stall && ({sk_out, sk_round, sk_last} !== prev_out)) stall_glitch++;
            sk_ready = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject != 0 && n == 5) begin
                key_in    = 64'h0000000000000000;
                decrypt   = 1'b1;
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            if (sk_valid && sk_ready) begin
                cap_sk[n]   = sk_out;
                cap_rnd[n]  = sk_round;
                cap_last[n] = sk_last;
                n++;
            end
            prev_stall = sk_valid && !sk_ready;
            if (prev_stall) stall_cycles++;
            prev_out = {sk_out, sk_round, sk_last};
        end
        key_valid = 1'b0;
        if (n < 16) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_in = '0; key_valid = 1'b0; decrypt = 1'b0; sk_ready = 1'b0;
        #2;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst_key_ready: got %b expected 1", key_ready); end
        checks++; if (sk_valid !== 1'b0) begin errors++; $display("FAIL rst_sk_valid: got %b expected 0", sk_valid); end
        checks++; if (sk_last !== 1'b0) begin errors++; $display("FAIL rst_sk_last: got %b expected 0", sk_last); end
        checks++; if (sk_round !== 4'd0) begin errors++; $display("FAIL rst_sk_round: got %0d expected 0", sk_round); end
        checks++; if (sk_out !== 48'h0) begin errors++; $display("FAIL rst_sk_out: got %h expected 0", sk_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_encrypt();
        load_key(TEST_KEY, 1'b0);
        checks++; if (sk_valid !== 1'b1) begin errors++; $display("FAIL enc_latency: sk_valid %b expected 1", sk_valid); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL enc_busy: key_ready %b expected 0", key_ready); end
        consume_stream(0, 0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL enc_timeout: got %b expected 0", timed_out); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_sk[i] !== k_exp[i]) begin errors++; $display("FAIL enc_sk[%0d]: got %h expected %h", i, cap_sk[i], k_exp[i]); end
            checks++; if (cap_rnd[i] !== 4'(i)) begin errors++; $display("FAIL enc_round[%0d]: got %0d expected %0d", i, cap_rnd[i], i); end
            checks++; if (cap_last[i] !== (i == 15)) begin errors++; $display("FAIL enc_last[%0d]: got %b expected %b", i, cap_last[i], (i == 15)); end
        end
        @(negedge clk);
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL enc_ready_back: got %b expected 1", key_ready); end
        checks++; if (sk_valid !== 1'b0) begin errors++; $display("FAIL enc_valid_drop: got %b expected 0", sk_valid); end
    endtask

    task automatic test_decrypt();
        load_key(TEST_KEY, 1'b1);
        consume_stream(0, 0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL dec_timeout: got %b expected 0", timed_out); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_sk[i] !== k_exp[15 - i]) begin errors++; $display("FAIL dec_sk[%0d]: got %h expected %h", i, cap_sk[i], k_exp[15 - i]); end
            checks++; if (cap_last[i] !== (i == 15)) begin errors++; $display("FAIL dec_last[%0d]: got %b expected %b", i, cap_last[i], (i == 15)); end
        end
        @(negedge clk);
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL dec_ready_back: got %b expected 1", key_ready); end
    endtask

    task automatic test_back_pressure();
        load_key(TEST_KEY, 1'b0);
        consume_stream(1, 0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b expected 0", timed_out); end
        checks++; if (stall_glitch !== 0) begin errors++; $display("FAIL bp_stable: %0d changes while stalled, expected 0", stall_glitch); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_sk[i] !== k_exp[i]) begin errors++; $display("FAIL bp_sk[%0d]: got %h expected %h", i, cap_sk[i], k_exp[i]); end
            checks++; if (cap_rnd[i] !== 4'(i)) begin errors++; $display("FAIL bp_round[%0d]: got %0d expected %0d", i, cap_rnd[i], i); end
        end
    endtask

    task automatic test_parity_and_ignore();
        load_key(PAR_KEY, 1'b0);
        consume_stream(0, 0);
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_sk[i] !== k_exp[i]) begin errors++; $display("FAIL parity_sk[%0d]: got %h expected %h", i, cap_sk[i], k_exp[i]); end
        end
        load_key(TEST_KEY, 1'b0);
        consume_stream(0, 1);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL ignore_timeout: got %b expected 0", timed_out); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_sk[i] !== k_exp[i]) begin errors++; $display("FAIL ignore_sk[%0d]: got %h expected %h", i, cap_sk[i], k_exp[i]); end
        end
        @(negedge clk);
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL ignore_ready_back: got %b expected 1", key_ready); end
    endtask

    task automatic test_reset_midstream();
        logic found;
        found = 1'b0;
        load_key(TEST_KEY, 1'b0);
        sk_ready = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (sk_round == 4'd7) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach_round7: got %b expected 1", found); end
        checks++; if (sk_out !== k_exp[7]) begin errors++; $display("FAIL mid_sk7: got %h expected %h", sk_out, k_exp[7]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_key_ready: got %b expected 1", key_ready); end
        checks++; if (sk_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_sk_valid: got %b expected 0", sk_valid); end
        checks++; if (sk_round !== 4'd0) begin errors++; $display("FAIL mid_rst_sk_round: got %0d expected 0", sk_round); end
        checks++; if (sk_out !== 48'h0) begin errors++; $display("FAIL mid_rst_sk_out: got %h expected 0", sk_out); end
        sk_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_key(TEST_KEY, 1'b0);
        checks++; if (sk_out !== k_exp[0]) begin errors++; $display("FAIL mid_fresh_k1: got %h expected %h", sk_out, k_exp[0]); end
        checks++; if (sk_round !== 4'd0) begin errors++; $display("FAIL mid_fresh_round: got %0d expected 0", sk_round); end
        consume_stream(0, 0);
        checks++; if (cap_sk[15] !== k_exp[15]) begin errors++; $display("FAIL mid_fresh_k16: got %h expected %h", cap_sk[15], k_exp[15]); end
    endtask

    task automatic test_zero_ones();
        load_key(64'h0000000000000000, 1'b0);
        consume_stream(0, 0);
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_sk[i] !== 48'h000000000000) begin errors++; $display("FAIL zero_sk[%0d]: got %h expected 0", i, cap_sk[i]); end
        end
        load_key(64'hFFFFFFFFFFFFFFFF, 1'b1);
        consume_stream(0, 0);
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap_sk[i] !== 48'hFFFFFFFFFFFF) begin errors++; $display("FAIL ones_sk[%0d]: got %h expected ffffffffffff", i, cap_sk[i]); end
        end
        @(negedge clk);
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL ones_ready_back: got %b expected 1", key_ready); end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_back_pressure();
        test_parity_and_ignore();
        test_reset_midstream();
        test_zero_ones();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
